// File: rtl/bp_be_dcache_replay_buffer_pkg.sv
// Shared defaults and elaboration helpers for the dcache replay buffer.
// Payload packing stays with the instantiating harness, so this package
// only carries parameter defaults and a helper used by the structural checks.
package bp_be_dcache_replay_buffer_pkg;

    localparam int default_els_lp         = 8;
    localparam int default_max_replays_lp = 15;

    // True when n is a power of two that is at least 2.
    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bp_be_dcache_replay_buffer_replay_ptr.sv
// Wrap-bit pointer register used for the write, read and checkpoint pointers.
// A load takes priority over an increment; arithmetic wraps naturally
// modulo 2^width_p, i.e. modulo twice the buffer depth.
module bp_be_replay_ptr #(
    parameter int width_p = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               inc_i,
    input  logic               load_v_i,
    input  logic [width_p-1:0] load_i,
    output logic [width_p-1:0] ptr_o
);

    // Pointer state: reset to zero, then load or advance by one.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_o <= '0;
        end else if (load_v_i) begin
            ptr_o <= load_i;
        end else if (inc_i) begin
            ptr_o <= ptr_o + width_p'(1);
        end
    end

endmodule

// File: rtl/bsg_mem_1r1w.sv
// One-read one-write storage array: synchronous write, asynchronous read.
// There is no write-to-read bypass, so a word written this cycle is only
// visible on the read port after the clock edge.
module bsg_mem_1r1w #(
    parameter int width_p       = 8,
    parameter int els_p         = 8,
    parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    // Write port: store the word at the addressed entry on the clock edge.
    always_ff @(posedge w_clk_i) begin
        if (w_v_i) begin
            mem[w_addr_i] <= w_data_i;
        end
    end

    assign r_data_o = mem[r_addr_i];

endmodule

// File: rtl/bp_be_dcache_replay_buffer.sv
// Checkpointed replay FIFO between the dcache request source and the dcache.
// Entries are dispatched speculatively and stay resident until committed;
// a rollback rewinds dispatch to the oldest uncommitted entry, and a
// saturating counter flags repeated rollbacks without forward progress.
module bp_be_dcache_replay_buffer
    import bp_be_dcache_replay_buffer_pkg::*;
#(
    parameter int width_p       = 8,
    parameter int els_p         = default_els_lp,
    parameter int max_replays_p = default_max_replays_lp
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [width_p-1:0]                 data_i,
    input  logic                               v_i,
    output logic                               ready_o,
    output logic [width_p-1:0]                 data_o,
    output logic                               v_o,
    input  logic                               yumi_i,
    input  logic                               ckpt_v_i,
    input  logic                               roll_v_i,
    input  logic                               clr_v_i,
    output logic [$clog2(els_p+1)-1:0]         inflight_o,
    output logic [$clog2(els_p+1)-1:0]         count_o,
    output logic [$clog2(max_replays_p+1)-1:0] replay_cnt_o,
    output logic                               replay_limit_o
);

    localparam int ptr_width_lp  = $clog2(els_p) + 1;
    localparam int addr_width_lp = ptr_width_lp - 1;
    localparam int cnt_width_lp  = $clog2(els_p + 1);
    localparam int rc_width_lp   = $clog2(max_replays_p + 1);

    logic [ptr_width_lp-1:0] wptr, rptr, cptr, cptr_next;
    logic [ptr_width_lp-1:0] count_raw, inflight_raw;
    logic                    write_en, read_en, ckpt_accept;
    logic                    rptr_load;
    logic [rc_width_lp-1:0]  replay_cnt;

    assign count_raw    = wptr - cptr;
    assign inflight_raw = rptr - cptr;

    assign ready_o    = (count_raw != ptr_width_lp'(els_p));
    assign v_o        = (rptr != wptr);
    assign count_o    = cnt_width_lp'(count_raw);
    assign inflight_o = cnt_width_lp'(inflight_raw);

    // A clear discards the read-side controls, so a commit only counts when
    // something is in flight and no clear is happening this cycle.
    assign write_en    = v_i & ready_o;
    assign read_en     = yumi_i & v_o & ~roll_v_i & ~clr_v_i;
    assign ckpt_accept = ckpt_v_i & (inflight_raw != '0) & ~clr_v_i;

    // The rollback target is the checkpoint as it will stand after this
    // cycle's commit, so a same-cycle commit is not replayed.
    assign cptr_next = clr_v_i ? wptr : (cptr + ptr_width_lp'(ckpt_accept));
    assign rptr_load = clr_v_i | roll_v_i;

    bp_be_replay_ptr #(.width_p(ptr_width_lp)) wptr_reg (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (write_en),
        .load_v_i (1'b0),
        .load_i   ('0),
        .ptr_o    (wptr)
    );

    bp_be_replay_ptr #(.width_p(ptr_width_lp)) rptr_reg (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (read_en),
        .load_v_i (rptr_load),
        .load_i   (cptr_next),
        .ptr_o    (rptr)
    );

    bp_be_replay_ptr #(.width_p(ptr_width_lp)) cptr_reg (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .inc_i    (ckpt_accept),
        .load_v_i (clr_v_i),
        .load_i   (wptr),
        .ptr_o    (cptr)
    );

    bsg_mem_1r1w #(
        .width_p (width_p),
        .els_p   (els_p)
    ) storage (
        .w_clk_i  (clk_i),
        .w_v_i    (write_en),
        .w_addr_i (wptr[addr_width_lp-1:0]),
        .w_data_i (data_i),
        .r_addr_i (rptr[addr_width_lp-1:0]),
        .r_data_o (data_o)
    );

    // Consecutive-rollback counter: any forward progress or clear restarts it,
    // a rollback without progress advances it up to the saturation value.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            replay_cnt <= '0;
        end else if (clr_v_i | ckpt_accept) begin
            replay_cnt <= '0;
        end else if (roll_v_i && (replay_cnt != rc_width_lp'(max_replays_p))) begin
            replay_cnt <= replay_cnt + rc_width_lp'(1);
        end
    end

    assign replay_cnt_o   = replay_cnt;
    assign replay_limit_o = (replay_cnt == rc_width_lp'(max_replays_p));

    // Protocol and configuration checks for simulation.
    a_depth_pow2:    assert property (@(posedge clk_i) is_pow2(els_p));
    a_enq_when_full: assert property (@(posedge clk_i) disable iff (reset_i) v_i |-> ready_o);
    a_yumi_no_data:  assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);
    a_ckpt_nothing:  assert property (@(posedge clk_i) disable iff (reset_i) ckpt_v_i |-> (inflight_raw != '0));

endmodule

// File: tb/tb_bp_be_dcache_replay_buffer.sv
// Self-checking bench for the replay buffer, using a queue-based model of
// stored entries plus a count of how many of them have been dispatched.
module tb_bp_be_dcache_replay_buffer;

    localparam int W    = 8;
    localparam int ELS  = 8;
    localparam int MAXR = 15;
    localparam int CW   = 4;
    localparam int RW   = 4;

    logic          clk = 1'b0;
    logic          reset, v_i, yumi, ckpt, roll, clr;
    logic [W-1:0]  data_i, data_o;
    logic          ready, v_o, lim;
    logic [CW-1:0] inflight, count;
    logic [RW-1:0] rc;

    int total  = 0;
    int passed = 0;

    logic [W-1:0] q[$];
    int           disp;
    int           m_rc;
    logic [W-1:0] fillv[ELS];

    bp_be_dcache_replay_buffer #(
        .width_p       (W),
        .els_p         (ELS),
        .max_replays_p (MAXR)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .data_i         (data_i),
        .v_i            (v_i),
        .ready_o        (ready),
        .data_o         (data_o),
        .v_o            (v_o),
        .yumi_i         (yumi),
        .ckpt_v_i       (ckpt),
        .roll_v_i       (roll),
        .clr_v_i        (clr),
        .inflight_o     (inflight),
        .count_o        (count),
        .replay_cnt_o   (rc),
        .replay_limit_o (lim)
    );

    always #5 clk = ~clk;

    // Advance one clock: update the model from the driven inputs, then idle them.
    task automatic tick();
        bit aw, ay, ac;
        aw = v_i && (q.size() < ELS);
        ay = yumi && (disp < q.size());
        ac = ckpt && (disp > 0);
        if (reset) begin
            q.delete(); disp = 0; m_rc = 0;
        end else if (clr) begin
            q.delete(); disp = 0; m_rc = 0;
            if (aw) q.push_back(data_i);
        end else begin
            if (ac) begin void'(q.pop_front()); disp--; end
            if (roll) disp = 0;
            else if (ay) disp++;
            if (aw) q.push_back(data_i);
            if (ac) m_rc = 0;
            else if (roll && m_rc < MAXR) m_rc++;
        end
        @(posedge clk);
        #1;
        {reset, v_i, yumi, ckpt, roll, clr} = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; v_i = 1'b1; data_i = 8'h11;
        tick();
        total++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready got=%0b exp=1", ready); else passed++;
        total++; if (v_o !== 1'b0) $display("[TB] FAIL reset_v got=%0b exp=0", v_o); else passed++;
        total++; if (count !== 4'd0) $display("[TB] FAIL reset_count got=%0d exp=0", count); else passed++;
        total++; if (inflight !== 4'd0) $display("[TB] FAIL reset_inflight got=%0d exp=0", inflight); else passed++;
        total++; if (rc !== 4'd0) $display("[TB] FAIL reset_rc got=%0d exp=0", rc); else passed++;
        total++; if (lim !== 1'b0) $display("[TB] FAIL reset_limit got=%0b exp=0", lim); else passed++;
    endtask

    task automatic fill_all();
        for (int i = 0; i < ELS; i++) begin
            fillv[i] = W'($urandom);
            v_i = 1'b1; data_i = fillv[i];
            tick();
        end
    endtask

    task automatic test_fill();
        fill_all();
        total++; if (ready !== 1'b0) $display("[TB] FAIL fill_ready got=%0b exp=0", ready); else passed++;
        total++; if (count !== 4'd8) $display("[TB] FAIL fill_count got=%0d exp=8", count); else passed++;
        total++; if (v_o !== 1'b1) $display("[TB] FAIL fill_v got=%0b exp=1", v_o); else passed++;
        total++; if (data_o !== fillv[0]) $display("[TB] FAIL fill_head got=%h exp=%h", data_o, fillv[0]); else passed++;
    endtask

    task automatic test_rollback();
        for (int i = 0; i < 3; i++) begin
            total++; if (data_o !== fillv[i]) $display("[TB] FAIL disp_order got=%h exp=%h", data_o, fillv[i]); else passed++;
            yumi = 1'b1; tick();
        end
        total++; if (inflight !== 4'd3) $display("[TB] FAIL disp3_inflight got=%0d exp=3", inflight); else passed++;
        ckpt = 1'b1; tick();
        roll = 1'b1; tick();
        total++; if (inflight !== 4'd0) $display("[TB] FAIL roll_inflight got=%0d exp=0", inflight); else passed++;
        total++; if (data_o !== fillv[1]) $display("[TB] FAIL roll_data got=%h exp=%h", data_o, fillv[1]); else passed++;
        total++; if (rc !== 4'd1) $display("[TB] FAIL roll_rc got=%0d exp=1", rc); else passed++;
        total++; if (count !== 4'd7) $display("[TB] FAIL roll_count got=%0d exp=7", count); else passed++;
    endtask

    task automatic test_full_dispatched();
        reset = 1'b1; tick();
        fill_all();
        for (int i = 0; i < ELS; i++) begin yumi = 1'b1; tick(); end
        total++; if (v_o !== 1'b0) $display("[TB] FAIL alldisp_v got=%0b exp=0", v_o); else passed++;
        total++; if (ready !== 1'b0) $display("[TB] FAIL alldisp_ready got=%0b exp=0", ready); else passed++;
        total++; if (inflight !== 4'd8) $display("[TB] FAIL alldisp_inflight got=%0d exp=8", inflight); else passed++;
        ckpt = 1'b1; tick();
        total++; if (ready !== 1'b1) $display("[TB] FAIL commit_ready got=%0b exp=1", ready); else passed++;
        total++; if (count !== 4'd7) $display("[TB] FAIL commit_count got=%0d exp=7", count); else passed++;
    endtask

    task automatic test_replay_saturation();
        for (int i = 0; i < 16; i++) begin
            roll = 1'b1; tick();
            if (i == 14) begin
                total++; if (rc !== 4'd15) $display("[TB] FAIL rc15 got=%0d exp=15", rc); else passed++;
            end
        end
        total++; if (rc !== 4'd15) $display("[TB] FAIL rc_sat got=%0d exp=15", rc); else passed++;
        total++; if (lim !== 1'b1) $display("[TB] FAIL limit_set got=%0b exp=1", lim); else passed++;
        yumi = 1'b1; tick();
        ckpt = 1'b1; tick();
        total++; if (rc !== 4'd0) $display("[TB] FAIL rc_clear got=%0d exp=0", rc); else passed++;
        total++; if (lim !== 1'b0) $display("[TB] FAIL limit_clear got=%0b exp=0", lim); else passed++;
    endtask

    task automatic test_clear();
        yumi = 1'b1; tick();
        clr = 1'b1; v_i = 1'b1; data_i = 8'hA5; yumi = 1'b1;
        tick();
        total++; if (count !== 4'd1) $display("[TB] FAIL clr_count got=%0d exp=1", count); else passed++;
        total++; if (data_o !== 8'hA5) $display("[TB] FAIL clr_data got=%h exp=a5", data_o); else passed++;
        total++; if (inflight !== 4'd0) $display("[TB] FAIL clr_inflight got=%0d exp=0", inflight); else passed++;
        total++; if (v_o !== 1'b1) $display("[TB] FAIL clr_v got=%0b exp=1", v_o); else passed++;
    endtask

    task automatic test_wrap();
        reset = 1'b1; tick();
        for (int i = 0; i < 20; i++) begin
            if (q.size() < ELS) begin v_i = 1'b1; data_i = W'($urandom); end
            if (disp < q.size()) begin
                total++; if (data_o !== q[disp]) $display("[TB] FAIL wrap_order got=%h exp=%h", data_o, q[disp]); else passed++;
                yumi = 1'b1;
            end
            if (disp > 0) ckpt = 1'b1;
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            v_i = 1'b1; data_i = W'($urandom); tick();
        end
        yumi = 1'b1; tick();
        yumi = 1'b1; tick();
        roll = 1'b1; tick();
        total++; if (data_o !== q[0]) $display("[TB] FAIL wrap_roll got=%h exp=%h", data_o, q[0]); else passed++;
        total++; if (count !== CW'(q.size())) $display("[TB] FAIL wrap_count got=%0d exp=%0d", count, q.size()); else passed++;
        reset = 1'b1; v_i = 1'b1; data_i = 8'h3C; yumi = 1'b1; roll = 1'b1;
        tick();
        total++; if ({ready, v_o, count, inflight, rc, lim} !== {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0})
            $display("[TB] FAIL midreset got=%b exp=%b", {ready, v_o, count, inflight, rc, lim}, {1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0});
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (q.size() < ELS && $urandom_range(0, 99) < 60) begin v_i = 1'b1; data_i = W'($urandom); end
            if (disp < q.size() && $urandom_range(0, 99) < 55) yumi = 1'b1;
            if (disp > 0 && $urandom_range(0, 99) < 30) ckpt = 1'b1;
            if ($urandom_range(0, 99) < 8) roll = 1'b1;
            if ($urandom_range(0, 99) < 3) clr = 1'b1;
            if ($urandom_range(0, 199) < 1) reset = 1'b1;
            tick();
            total++; if (count !== CW'(q.size())) $display("[TB] FAIL rnd_count cyc=%0d got=%0d exp=%0d", i, count, q.size()); else passed++;
            total++; if (inflight !== CW'(disp)) $display("[TB] FAIL rnd_inflight cyc=%0d got=%0d exp=%0d", i, inflight, disp); else passed++;
            total++; if (v_o !== (disp < q.size())) $display("[TB] FAIL rnd_v cyc=%0d got=%0b exp=%0b", i, v_o, disp < q.size()); else passed++;
            total++; if (ready !== (q.size() < ELS)) $display("[TB] FAIL rnd_ready cyc=%0d got=%0b exp=%0b", i, ready, q.size() < ELS); else passed++;
            total++; if (rc !== RW'(m_rc)) $display("[TB] FAIL rnd_rc cyc=%0d got=%0d exp=%0d", i, rc, m_rc); else passed++;
            total++; if (lim !== (m_rc == MAXR)) $display("[TB] FAIL rnd_limit cyc=%0d got=%0b exp=%0b", i, lim, m_rc == MAXR); else passed++;
            if (disp < q.size()) begin
                total++; if (data_o !== q[disp]) $display("[TB] FAIL rnd_data cyc=%0d got=%h exp=%h", i, data_o, q[disp]); else passed++;
            end
        end
    endtask

    initial begin
        {reset, v_i, yumi, ckpt, roll, clr} = '0;
        data_i = '0;
        disp = 0; m_rc = 0;
        test_reset();
        test_fill();
        test_rollback();
        test_full_dispatched();
        test_replay_saturation();
        test_clear();
        test_wrap();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
